// File: rtl/in_unit_pkg.sv
// rtl/in_unit_pkg.sv - shared widths and CDB broadcast type for the IN unit
package in_unit_pkg;

  localparam int ROB_WIDTH = 6;
  localparam int N_B_ENTRY = 4;
  localparam int B_CNT_W   = $clog2(N_B_ENTRY) + 1;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

endpackage

// File: rtl/req_if.sv
// rtl/req_if.sv - valid/ready request handshake
interface req_if;
  logic valid;
  logic ready;

  modport req (output valid, input ready);
  modport rsp (input valid, output ready);
endinterface

// File: rtl/in_fifo.sv
// rtl/in_fifo.sv - byte FIFO between the UART receiver and the IN queue
// Push while full is accepted only when a pop happens in the same cycle.
module in_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/in_unit.sv
// rtl/in_unit.sv - IN instruction queue pairing received bytes with issued INs
// The oldest non-speculative IN takes the FIFO head and broadcasts it on the CDB.
module in_unit
  import in_unit_pkg::*;
#(
  parameter int N_ENTRY    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 receiver_valid,
  input  logic [7:0]           receiver_out,
  output logic                 receiver_ready,
  req_if.rsp                   issue_req,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  input  logic [B_CNT_W-1:0]   b_count_next,
  input  logic                 b_commit,
  input  logic                 failure,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output cdb_t                 in_cdb
);

  localparam int CNT_W = $clog2(N_ENTRY + 1);

  typedef struct packed {
    logic [ROB_WIDTH-1:0] tag;
    logic [B_CNT_W-1:0]   b_count;
  } in_entry_t;

  in_entry_t        ents_q [N_ENTRY];
  in_entry_t        ents_d [N_ENTRY];
  logic [CNT_W-1:0] count_q, count_d;
  cdb_t             cdb_q, cdb_d;

  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic             fire, accept, run;
  logic [CNT_W-1:0] prefix, slot;

  in_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (receiver_valid && receiver_ready),
    .din_i   (receiver_out),
    .pop_i   (fire),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cdb_req         = (count_q != '0) && (ents_q[0].b_count == '0) && !fifo_empty;
  assign fire            = cdb_req && cdb_grant;
  assign receiver_ready  = !fifo_full || fire;
  assign issue_req.ready = fire || (count_q < CNT_W'(N_ENTRY));
  assign accept          = issue_req.valid && issue_req.ready && !failure;
  assign in_cdb          = cdb_q;

  always_comb begin
    ents_d = ents_q;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (CNT_W'(i) < count_q && ents_q[i].b_count != '0)
        ents_d[i].b_count = ents_q[i].b_count - B_CNT_W'(b_commit);
    end
    // Ascending order reads each upper slot before it is overwritten.
    if (fire) begin
      for (int i = 0; i < N_ENTRY - 1; i++) begin
        if (CNT_W'(i + 1) < count_q) ents_d[i] = ents_d[i + 1];
      end
    end
    slot = count_q - CNT_W'(fire);
    for (int i = 0; i < N_ENTRY; i++) begin
      if (accept && CNT_W'(i) == slot) begin
        ents_d[i].tag     = issue_tag;
        ents_d[i].b_count = b_count_next;
      end
    end
  end

  // On a flush only the leading run of non-speculative entries survives.
  always_comb begin
    prefix = '0;
    run    = 1'b1;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (run && CNT_W'(i) < count_q && ents_q[i].b_count == '0)
        prefix = prefix + CNT_W'(1);
      else
        run = 1'b0;
    end
    if (failure) count_d = prefix - CNT_W'(fire);
    else         count_d = count_q - CNT_W'(fire) + CNT_W'(accept);
  end

  always_comb begin
    cdb_d = '0;
    if (fire) begin
      cdb_d.valid = 1'b1;
      cdb_d.tag   = ents_q[0].tag;
      cdb_d.data  = {24'b0, fifo_head};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      cdb_q   <= '0;
      for (int i = 0; i < N_ENTRY; i++) ents_q[i] <= '0;
    end else begin
      count_q <= count_d;
      cdb_q   <= cdb_d;
      for (int i = 0; i < N_ENTRY; i++) ents_q[i] <= ents_d[i];
    end
  end

endmodule

// File: doc/in_unit.md
Name: in_unit

Overview:
- Receive-side counterpart of the OUT unit.
- Buffers bytes arriving from the UART receiver in a byte FIFO.
- Holds issued IN instructions in an in-order queue.
- Once the oldest IN is non-speculative (no unresolved older branches) and a byte is available, pops both and broadcasts the zero-extended byte on the GPR CDB under the instruction's ROB tag.

Parameters:
- N_ENTRY, 4, depth of the IN instruction queue.
- FIFO_DEPTH, 16, depth of the receive byte FIFO (power of two).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- receiver_valid  input  1  UART receiver has a byte.
- receiver_out  input  8  received byte.
- receiver_ready  output  1  FIFO accepts the byte this cycle.
- issue_req  modport  req_if  issue handshake (valid in, ready out).
- issue_tag  input  ROB_WIDTH  ROB tag of the IN being issued.
- b_count_next  input  $clog2(N_B_ENTRY)+1  unresolved-branch count for the issuing instruction.
- b_commit  input  1  one branch resolved correctly this cycle.
- failure  input  1  branch mispredict flush.
- cdb_req  output  1  request for the GPR CDB.
- cdb_grant  input  1  CDB granted this cycle.
- in_cdb  output  cdb_t  result broadcast: valid, tag, data[31:0].

Behaviour:
- Reset (async, rst=1):
  - queue count=0, FIFO empty;
  - in_cdb.valid=0, cdb_req=0;
  - receiver_ready=1 after reset release; issue_req.ready=1.
- Entry fields: tag, b_count.
  - Per cycle, b_count <= (b_count==0 ? 0 : b_count-b_commit).
  - A new entry takes issue_tag and b_count_next unmodified.
- FIFO:
  - push = receiver_valid && receiver_ready.
  - receiver_ready = !full || pop; simultaneous push and pop at full is legal.
  - Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- cdb_req = count!=0 && e[0].b_count==0 && !fifo_empty (combinational).
- fire = cdb_req && cdb_grant. On fire:
  - pop e[0] and the FIFO head;
  - shift entries down one;
  - in_cdb registered next cycle: valid=1, tag=e[0].tag, data={24'b0, fifo_head}.
  - Latency: grant cycle to CDB valid = 1 cycle.
  - in_cdb.valid=0 in any cycle following a non-fire cycle.
- issue_req.ready = fire || count<N_ENTRY.
  - Accept = issue_req.valid && issue_req.ready.
  - Accept and fire in the same cycle with count==N_ENTRY is legal; the new entry lands in slot N_ENTRY-1.
- count next:
  - no failure: count - fire + accept;
  - failure: length of the prefix of entries with b_count==0, minus fire. Issue is ignored that cycle.
- Failure never discards FIFO bytes.
  - A fire coinciding with failure still completes: its entry has b_count==0, so it is non-speculative.
- Empty queue with FIFO bytes: bytes are held and the FIFO fills; receiver stalls when full.
- Queue entries waiting on an empty FIFO hold cdb_req=0 indefinitely.
- Slots >= count are don't-care but must be written only by accept.

Decomposition:
- Shared package/common.vh: ROB_WIDTH, N_B_ENTRY, cdb_t, req_if.
- in_entry typedef (tag, b_count) is local to the module.
- One sub-module, in_fifo: parameterised byte FIFO with push/pop, full/empty, async active-high reset.
- Instruction queue and fire logic stay in in_unit.

Test Plan:
- Reset mid-operation: FIFO holding 3 bytes, 2 entries, assert rst -> count=0, FIFO empty, in_cdb.valid=0 immediately; no broadcast after release.
- Basic order:
  - Push 0x41, 0x42; issue tags 5 then 6 with b_count_next=0, cdb_grant=1.
  - Expected: in_cdb {1,5,0x00000041} then {1,6,0x00000042} on consecutive cycles.
- Speculation:
  - Issue tag 3 with b_count_next=1, byte present.
  - Expected: cdb_req=0 until b_commit pulses, then cdb_req=1; broadcast one cycle after grant.
- Failure:
  - Entries b_count {0,0,1,2}, failure, no grant.
  - Expected: count=2 next cycle, FIFO occupancy unchanged, the issue_req.valid that cycle is not accepted.
- Full boundaries:
  - Fill FIFO with 16 bytes: receiver_ready=0, and becomes 1 in the same cycle a fire occurs.
  - With 4 entries queued: issue_req.ready=0 except in a fire cycle, where the accepted tag lands in slot 3.
- Grant withheld: cdb_req=1 with cdb_grant=0 for 5 cycles -> no pop, no broadcast; state is stable.
